// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU execution stage: opcodes, FSM
// state encodings and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 5;

    localparam logic OP_NOT = 1'b0;
    localparam logic OP_ROL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ROT  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_seq_exec.sv
// Sequential ALU stage: single-cycle NOT and iterative rotate-left (one bit per
// cycle), with registered result/flag and a one-cycle valid pulse in DONE.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             OP,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             busy,
    output logic             valid
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] shreg_rol;

    assign shreg_rol = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flag_d   = flag_q;

        unique case (state_q)
            ST_ROT: begin
                shreg_d = shreg_rol;
                cnt_d   = cnt_q - CNT_W'(1);
                // Full B iterations even when B >= WIDTH; the rotation wraps naturally.
                if (cnt_q == CNT_W'(1)) begin
                    result_d = shreg_rol;
                    flag_d   = |shreg_rol;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new op, so start held high streams ops.
                if (start) begin
                    unique case (OP)
                        OP_NOT: begin
                            result_d = ~A;
                            flag_d   = |(~A);
                            state_d  = ST_DONE;
                        end
                        OP_ROL: begin
                            if (B == '0) begin
                                result_d = A;
                                flag_d   = |A;
                                state_d  = ST_DONE;
                            end else begin
                                shreg_d = A;
                                cnt_d   = CNT_W'(B);
                                state_d = ST_ROT;
                            end
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign result = result_q;
    assign flag   = flag_q;
    assign busy   = (state_q == ST_ROT);
    assign valid  = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: expected results are queued at issue and
// compared whenever valid is seen; latency and busy duration are also checked.
module tb_alu_seq_exec;

    logic       clk;
    logic       reset_n;
    logic [4:0] A;
    logic [4:0] B;
    logic       OP;
    logic       start;
    logic [4:0] result;
    logic       flag;
    logic       busy;
    logic       valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_q[$];   // {flag, result}

    alu_seq_exec dut (
        .clk    (clk),
        .reset_n(reset_n),
        .A      (A),
        .B      (B),
        .OP     (OP),
        .start  (start),
        .result (result),
        .flag   (flag),
        .busy   (busy),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] model(input logic op, input logic [4:0] a, input logic [4:0] b);
        logic [4:0] v;
        if (op == 1'b0) begin
            v = ~a;
        end else begin
            v = a;
            for (int i = 0; i < int'(b); i++) v = {v[3:0], v[4]};
        end
        return {(v != 5'd0), v};
    endfunction

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check_eq("result", 32'(result), 32'(e[4:0]));
                check_eq("flag", 32'(flag), 32'(e[5]));
                check_eq("busy_at_valid", 32'(busy), 32'd0);
            end
        end
    end

    task automatic do_op(input string tag, input logic op, input logic [4:0] a,
                         input logic [4:0] b);
        int lat;
        int busy_cnt;
        int exp_lat;
        @(negedge clk);
        A = a; B = b; OP = op; start = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        // Inputs are only sampled at the accepting edge.
        A = 5'($urandom); B = 5'($urandom); OP = 1'($urandom);
        exp_lat = (op == 1'b1 && b != 5'd0) ? int'(b) : 0;
        lat = 0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (valid) break;
            if (busy) busy_cnt++;
            lat++;
            if (lat > 64) begin
                check_eq({tag, "_timeout"}, 32'(lat), 32'(exp_lat));
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!valid) check_eq({tag, "_timeout"}, 32'(n), 32'(limit + 1));
    endtask

    initial begin
        reset_n = 1'b0;
        A = '0; B = '0; OP = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_flag", 32'(flag), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op("not_00101", 1'b0, 5'b00101, 5'd0);
        do_op("rol_10000_1", 1'b1, 5'b10000, 5'd1);
        do_op("not_00000", 1'b0, 5'b00000, 5'd0);
        do_op("not_11111", 1'b0, 5'b11111, 5'd0);
        do_op("rol_10110_7", 1'b1, 5'b10110, 5'd7);
        do_op("rol_10110_0", 1'b1, 5'b10110, 5'd0);
        do_op("rol_b31", 1'b1, 5'b10011, 5'd31);
        do_op("rol_b5", 1'b1, 5'b01101, 5'd5);

        // Start while busy is ignored: one valid, the rotate result only.
        @(negedge clk);
        A = 5'b00011; B = 5'd4; OP = 1'b1; start = 1'b1;
        exp_q.push_back(model(1'b1, 5'b00011, 5'd4));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        A = 5'b11111; OP = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        wait_valid("busy_ignore", 20);
        repeat (6) @(negedge clk);
        check_eq("busy_ignore_drained", 32'(exp_q.size()), 32'd0);

        // Start held high: a new NOT is accepted in every IDLE/DONE cycle.
        @(negedge clk);
        OP = 1'b0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = 5'(i * 7 + 3);
            exp_q.push_back(model(1'b0, A, 5'd0));
            @(posedge clk);
            #1;
            check_eq("stream_valid", 32'(valid), 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("stream_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-rotate aborts immediately with no valid pulse.
        @(negedge clk);
        A = 5'b00001; B = 5'd20; OP = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("abort_result", 32'(result), 32'd0);
        check_eq("abort_flag", 32'(flag), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_valid", 32'(valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        do_op("post_reset_not", 1'b0, 5'b00101, 5'd0);

        for (int i = 0; i < 10; i++) begin
            do_op("rand", 1'($urandom), 5'($urandom), 5'($urandom_range(0, 12)));
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
